// File: rtl/adex_param_frame_tx.sv
`timescale 1ns/1ps
// adex_param_frame_tx
// Sends one 64-bit AdEx parameter set to the neuron tile's nibble-serial
// loader. The frame is: arm (load_mode high, strobe line low), then 18
// load_enable strobes carrying start (0x0), 16 data nibbles (byte 0 first,
// high nibble first), and the 0xF footer. After the frame, load_mode is held
// high so the receiver can commit. A one-cycle done pulse ends the frame.
//
// Parameters
//   STROBE_HIGH  cycles load_enable is high per strobe        (1..255)
//   STROBE_LOW   cycles load_enable is low between strobes    (2..255)
//   HOLD_CYCLES  cycles load_mode stays high after the footer (1..255)
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset; clears every output
//   start        frame request, accepted only while idle
//   params       byte k = params[8k+7:8k]: DeltaT, TauW, a, b, Vreset, VT,
//                Ibias, C for k = 0..7; captured on the accepting cycle
//   busy         high from the cycle after acceptance through the hold phase
//   done         one-cycle completion pulse
//   load_mode    to receiver load_mode  (ui_in[4])
//   load_enable  to receiver load_enable (ui_in[3])
//   nibble_out   to receiver nibble bus (uio_in[3:0])
module adex_param_frame_tx #(
  parameter int unsigned STROBE_HIGH = 2,
  parameter int unsigned STROBE_LOW  = 2,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] params,
  output logic        busy,
  output logic        done,
  output logic        load_mode,
  output logic        load_enable,
  output logic [3:0]  nibble_out
);

  if (STROBE_HIGH < 1 || STROBE_HIGH > 255) begin : g_bad_strobe_high
    $fatal(1, "adex_param_frame_tx: STROBE_HIGH must be in 1..255");
  end
  // A low phase of 2 keeps every rising edge clear of the receiver's
  // one-cycle latch state.
  if (STROBE_LOW < 2 || STROBE_LOW > 255) begin : g_bad_strobe_low
    $fatal(1, "adex_param_frame_tx: STROBE_LOW must be in 2..255");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $fatal(1, "adex_param_frame_tx: HOLD_CYCLES must be in 1..255");
  end

  localparam logic [7:0] HIGH_LAST = 8'(STROBE_HIGH - 1);
  localparam logic [7:0] LOW_LAST  = 8'(STROBE_LOW - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [4:0] LAST_STROBE = 5'd17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state;
  logic [7:0]  phase;
  logic [4:0]  strobe;
  logic [63:0] shadow;
  logic [3:0]  next_nibble;

  // Nibble for strobe+1, presented on the falling edge of the current strobe.
  // For strobe s in 0..15 the next strobe carries data nibble s: byte s/2,
  // high nibble when s is even, so the bit offset is {s[3:1], ~s[0], 2'b00}.
  always_comb begin
    next_nibble = '0;
    if (strobe == 5'd16) begin
      next_nibble = 4'hF;
    end else if (strobe < 5'd16) begin
      next_nibble = shadow[{strobe[3:1], ~strobe[0], 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      phase       <= '0;
      strobe      <= '0;
      shadow      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_mode   <= 1'b0;
      load_enable <= 1'b0;
      nibble_out  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !busy) begin
            shadow      <= params;
            phase       <= '0;
            strobe      <= '0;
            busy        <= 1'b1;
            load_mode   <= 1'b1;
            load_enable <= 1'b0;
            nibble_out  <= '0;
            state       <= S_ARM;
          end
        end

        S_ARM: begin
          if (phase == LOW_LAST) begin
            phase       <= '0;
            strobe      <= '0;
            load_enable <= 1'b1;
            state       <= S_HIGH;
          end else begin
            phase <= phase + 8'd1;
          end
        end

        S_HIGH: begin
          if (phase == HIGH_LAST) begin
            phase       <= '0;
            load_enable <= 1'b0;
            // Footer value stays on the bus through the hold phase.
            if (strobe != LAST_STROBE) begin
              nibble_out <= next_nibble;
            end
            state <= S_LOW;
          end else begin
            phase <= phase + 8'd1;
          end
        end

        S_LOW: begin
          if (phase == LOW_LAST) begin
            phase <= '0;
            if (strobe == LAST_STROBE) begin
              state <= S_HOLD;
            end else begin
              strobe      <= strobe + 5'd1;
              load_enable <= 1'b1;
              state       <= S_HIGH;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end

        S_HOLD: begin
          if (phase == HOLD_LAST) begin
            phase      <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            load_mode  <= 1'b0;
            nibble_out <= '0;
            state      <= S_DONE;
          end else begin
            phase <= phase + 8'd1;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adex_param_frame_tx.sv
`timescale 1ns/1ps
// Bench for adex_param_frame_tx: a default-timing and a minimum-timing
// instance share stimulus; a timing model and a receiver model check them.
module tb_adex_param_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] params = '0;

  logic busy0, done0, lm0, le0, busy1, done1, lm1, le1;
  logic [3:0] nib0, nib1;

  logic [1:0] busy_v, done_v, lm_v, le_v;
  logic [3:0] nib_v [2];
  assign busy_v = {busy1, busy0};
  assign done_v = {done1, done0};
  assign lm_v   = {lm1, lm0};
  assign le_v   = {le1, le0};
  assign nib_v[0] = nib0;
  assign nib_v[1] = nib1;

  always #5 clk = ~clk;

  adex_param_frame_tx dut_def (
    .clk(clk), .rst_n(rst_n), .start(start), .params(params),
    .busy(busy0), .done(done0), .load_mode(lm0), .load_enable(le0),
    .nibble_out(nib0)
  );

  adex_param_frame_tx #(
    .STROBE_HIGH(1),
    .STROBE_LOW(2),
    .HOLD_CYCLES(1)
  ) dut_min (
    .clk(clk), .rst_n(rst_n), .start(start), .params(params),
    .busy(busy1), .done(done1), .load_mode(lm1), .load_enable(le1),
    .nibble_out(nib1)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  function automatic int sh_of(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int sl_of(int i); return 2; endfunction
  function automatic int hc_of(int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int busy_len(int i);
    return sl_of(i) + 18 * (sh_of(i) + sl_of(i)) + hc_of(i);
  endfunction
  function automatic int spacing_lit(int i); return (i == 0) ? 4 : 3; endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Nibble carried by strobe s of a frame with parameter set p.
  function automatic logic [3:0] nib_of(int s, logic [63:0] p);
    logic [7:0] b;
    if (s == 17) return 4'hF;
    if (s < 1) return 4'h0;
    b = p[8 * ((s - 1) / 2) +: 8];
    return (s % 2 == 1) ? b[7:4] : b[3:0];
  endfunction

  // Expected {busy, done, load_mode, load_enable, nibble} d cycles after acceptance.
  function automatic logic [7:0] expv(int d, int sh, int sl, int hc, logic [63:0] p);
    int per;
    int len;
    logic bz, dn, lm, le;
    logic [3:0] nb;
    per = sh + sl;
    len = sl + 18 * per + hc;
    bz = 1'b0; dn = 1'b0; lm = 1'b0; le = 1'b0; nb = 4'h0;
    if (d >= 1 && d <= len) begin
      bz = 1'b1;
      lm = 1'b1;
      for (int s = 1; s <= 17; s++)
        if (d >= 1 + sl + (s - 1) * per + sh) nb = nib_of(s, p);
    end
    if (d == len + 1) dn = 1'b1;
    for (int s = 0; s < 18; s++)
      if (d >= 1 + sl + s * per && d < 1 + sl + s * per + sh) le = 1'b1;
    return {bz, dn, lm, le, nb};
  endfunction

  // Transmitter model state
  bit          active [2];
  int          t0 [2];
  int          prev_t0 [2];
  int          acc_n [2];
  logic [63:0] shadow_m [2];

  // Receiver model state
  bit          le_p [2];
  bit          lm_p [2];
  int          edges [2];
  logic [3:0]  nibs [2][18];
  logic [63:0] committed [2];
  bit          ready [2];
  int          commits [2];
  int          last_edge [2];
  int          spacing_bad [2];
  int          lowrun [2];
  int          lm_gap [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      // receiver: watches the outputs of the cycle that is ending
      if (lm_v[i] && !lm_p[i]) begin
        edges[i]  = 0;
        ready[i]  = 1'b0;
        lm_gap[i] = lowrun[i];
      end
      if (!lm_v[i]) lowrun[i]++;
      else lowrun[i] = 0;
      if (lm_v[i] && le_v[i] && !le_p[i]) begin
        if (edges[i] > 0 && (cyc - last_edge[i]) != spacing_lit(i)) spacing_bad[i]++;
        last_edge[i] = cyc;
        if (edges[i] < 18) nibs[i][edges[i]] = nib_v[i];
        edges[i]++;
        if (edges[i] == 18 && nib_v[i] == 4'hF) begin
          for (int k = 0; k < 8; k++)
            committed[i][8 * k +: 8] = {nibs[i][2 * k + 1], nibs[i][2 * k + 2]};
          ready[i] = 1'b1;
          commits[i]++;
        end
      end
      if (!lm_v[i] && lm_p[i] && edges[i] < 18) ready[i] = 1'b0;
      lm_p[i] = lm_v[i];
      le_p[i] = le_v[i];

      // transmitter: acceptance only in idle (DONE cycle excluded)
      if (!rst_n) begin
        active[i] = 1'b0;
      end else if (start && (!active[i] || (cyc - t0[i]) > busy_len(i) + 1)) begin
        prev_t0[i]  = t0[i];
        t0[i]       = cyc;
        active[i]   = 1'b1;
        shadow_m[i] = params;
        acc_n[i]++;
      end
    end
    cyc++;
  end

  // Per-cycle trace comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e;
      logic [7:0] a;
      e = '0;
      if (rst_n && active[i])
        e = expv(cyc - t0[i], sh_of(i), sl_of(i), hc_of(i), shadow_m[i]);
      a = {busy_v[i], done_v[i], lm_v[i], le_v[i], nib_v[i]};
      check($sformatf("trace_dut%0d", i), 128'(a), 128'(e));
    end
  end

  task automatic send(input logic [63:0] p);
    @(negedge clk);
    params = p;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done0(output int bcnt);
    bit ok;
    ok = 1'b0;
    bcnt = busy_v[0] ? 1 : 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (busy_v[0]) bcnt++;
      if (done_v[0]) ok = 1'b1;
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  function automatic logic [71:0] nib_seq(int i);
    logic [71:0] v;
    v = '0;
    for (int n = 0; n < 18; n++) v = {v[67:0], nibs[i][n]};
    return v;
  endfunction

  localparam logic [63:0] P1 = 64'hC880_4E3F_2802_6482;
  localparam logic [63:0] P2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P3 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] P4 = 64'h5A5A_A5A5_3C3C_C3C3;
  localparam logic [63:0] P5 = 64'h1122_3344_5566_7788;

  initial begin
    int bcnt;
    int acc_before;
    int com_before;
    bit hit;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({busy_v, done_v, lm_v, le_v, nib_v[1], nib_v[0]}), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // default frame (and minimum-timing instance in parallel)
    send(P1);
    wait_done0(bcnt);
    check("busy_cycles", 128'(bcnt), 128'(78));
    check("done_cycle", 128'(cyc - t0[0]), 128'(79));
    check("edges_def", 128'(edges[0]), 128'(18));
    check("nibbles_def", 128'(nib_seq(0)), 128'(72'h0826402283F4E80C8F));
    check("commit_def", 128'(committed[0]), 128'(P1));
    check("ready_def", 128'(ready[0]), 128'(1));
    check("spacing_def", 128'(spacing_bad[0]), 128'(0));
    check("edges_min", 128'(edges[1]), 128'(18));
    check("commit_min", 128'(committed[1]), 128'(P1));
    check("spacing_min", 128'(spacing_bad[1]), 128'(0));
    check("ready_min", 128'(ready[1]), 128'(1));

    // start while busy is ignored
    repeat (3) @(negedge clk);
    acc_before = acc_n[0];
    send(P2);
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      if (cyc - t0[0] == 20) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) check("cycle20_timeout", 0, 1);
    params = P3;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    params = 64'hDEAD_BEEF_0BAD_F00D;
    wait_done0(bcnt);
    check("busy_start_ignored", 128'(acc_n[0] - acc_before), 128'(1));
    check("commit_busy_def", 128'(committed[0]), 128'(P2));
    check("commit_busy_min", 128'(committed[1]), 128'(P2));
    repeat (3) @(negedge clk);
    send(P3);
    wait_done0(bcnt);
    check("commit_next_def", 128'(committed[0]), 128'(P3));
    check("commit_next_min", 128'(committed[1]), 128'(P3));

    // asynchronous reset around strobe 9
    repeat (3) @(negedge clk);
    send(P4);
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk);
      if (edges[0] == 10) hit = 1'b1;
    end
    if (!hit) check("strobe9_timeout", 0, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             128'({busy_v, done_v, lm_v, le_v, nib_v[1], nib_v[0]}), 128'(0));
    @(negedge clk);
    check("reset_ready_def", 128'(ready[0]), 128'(0));
    check("reset_commit_def", 128'(committed[0]), 128'(P3));
    check("reset_ready_min", 128'(ready[1]), 128'(0));
    check("reset_commit_min", 128'(committed[1]), 128'(P3));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // back-to-back frames with start held high
    acc_before = acc_n[0];
    com_before = commits[0];
    params = P5;
    start  = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(negedge clk);
      if (commits[0] - com_before >= 2) hit = 1'b1;
    end
    if (!hit) check("b2b_timeout", 0, 1);
    check("b2b_accepts", 128'(acc_n[0] - acc_before), 128'(2));
    check("b2b_period", 128'(t0[0] - prev_t0[0]), 128'(80));
    check("b2b_lm_gap", 128'(lm_gap[0]), 128'(2));
    start = 1'b0;
    wait_done0(bcnt);
    check("b2b_commit", 128'(committed[0]), 128'(P5));
    repeat (70) @(negedge clk);
    check("b2b_commit_min", 128'(committed[1]), 128'(P5));

    // all-ones parameters: footer-valued data must not end the frame
    send('1);
    wait_done0(bcnt);
    check("ff_edges", 128'(edges[0]), 128'(18));
    check("ff_nibbles", 128'(nib_seq(0)), 128'(72'h0FFFFFFFFFFFFFFFFF));
    check("ff_commit_def", 128'(committed[0]), 128'({64{1'b1}}));
    check("ff_commit_min", 128'(committed[1]), 128'({64{1'b1}}));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adex_param_frame_tx.md
# adex_param_frame_tx

Parameter-frame transmitter for the AdEx neuron tile's nibble-serial configuration port. The block accepts a 64-bit parameter set (DeltaT, TauW, a, b, Vreset, VT, Ibias, C) through a start/busy/done handshake. It then drives load_mode, load_enable and a 4-bit nibble bus with the complete loader frame: arm, start strobe, 16 data nibbles, and the 0xF footer. It sits on the host/test-harness side, or in a neighbouring tile, and its outputs are wired straight to the neuron's ui_in[4], ui_in[3] and uio_in[3:0].

## Interface
- STROBE_HIGH, default 2: cycles load_enable stays high per strobe; legal range 1..255.
- STROBE_LOW, default 2: cycles load_enable stays low between strobes; legal range 2..255. The minimum of 2 guarantees that no rising edge lands in the receiver's one-cycle latch state.
- HOLD_CYCLES, default 4: cycles load_mode stays high after the footer strobe, so the receiver can commit and assert ready; legal range 1..255.
- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled high while idle and not busy, it begins a frame.
- params  in  64  byte k = params[8k+7:8k]; k=0 DeltaT, 1 TauW, 2 a, 3 b, 4 Vreset, 5 VT, 6 Ibias, 7 C. Captured on the accepting cycle.
- busy  out  1  high from the cycle after acceptance through the final cycle.
- done  out  1  one-cycle pulse marking frame completion.
- load_mode  out  1  to the receiver's load_mode pin.
- load_enable  out  1  to the receiver's load_enable pin.
- nibble_out  out  4  to the receiver's nibble bus.

## Operation
- All outputs are registered. During reset, and after reset, every output is 0.
- **IDLE**
  - When start=1 and busy=0: latch params into the shadow register.
  - Clear the strobe index s (5 bits) and the phase counter (8 bits).
  - Next state is ARM.
- **ARM**
  - load_mode=1, load_enable=0, nibble_out=0x0 for STROBE_LOW cycles.
  - Next state is HIGH with s=0.
- **HIGH**
  - load_enable=1 for STROBE_HIGH cycles.
  - Next state is LOW.
- **LOW**
  - load_enable=0 for STROBE_LOW cycles.
  - On the first LOW cycle, nibble_out is updated to the value for strobe s+1, so data is stable through the whole next low and high phase.
  - After LOW, s increments. If s was 17, next state is HOLD; otherwise next state is HIGH.
- Nibble schedule by strobe index:
  - s=0: start strobe, nibble 0x0. The receiver ignores its data.
  - s=1..16: byte k=(s-1)/2. The high nibble is sent first (odd s), the low nibble second (even s).
  - s=17: footer 0xF.
- **HOLD**
  - load_mode=1, load_enable=0 for HOLD_CYCLES cycles.
  - Next state is DONE.
- **DONE**
  - Lasts one cycle: load_mode=0, nibble_out=0x0, done=1, busy=0.
  - Next state is IDLE.
- start while busy is ignored; there is no queueing. The shadow register is immutable during a frame, so changes on params mid-frame have no effect.
- Behaviour for start asserted on the DONE cycle: that start is ignored. A new frame needs start in IDLE.
- Parameter ranges are checked at elaboration and out-of-range values are a fatal error. The maximum strobe gap (255+255 cycles) is far below the receiver watchdog of 50000 cycles.
- Reset mid-frame clears all outputs asynchronously. Dropping load_mode returns the receiver to its idle state. The receiver's committed parameters remain those of the last complete frame.

## Timing
- Acceptance is at cycle 0. load_mode and busy rise at cycle 1.
- The first load_enable rising edge occurs at cycle 1+STROBE_LOW.
- Strobe s rises at cycle 1 + STROBE_LOW + s·(STROBE_HIGH+STROBE_LOW).
- nibble_out changes only on cycles where load_enable falls, or at DONE. It never changes on the rising-edge cycle.
- busy stays high for STROBE_LOW + 18·(STROBE_HIGH+STROBE_LOW) + HOLD_CYCLES cycles. done then pulses on the following cycle, at the same time as load_mode falls.
- With default parameters: 78 busy cycles, done at cycle 79.
- Exactly 18 load_enable rising edges occur per frame.

## Test plan
- **Default frame.** params = 0x C8_80_4E_3F_28_02_64_82 (C..DeltaT), driven into the receiver model.
  - Required response: 18 rising edges.
  - Nibbles in order: 0,8,2,6,4,0,2,2,8,3,F,4,E,8,0,C,8,F.
  - done at cycle 79; receiver ready=1 with all eight bytes committed.
- **Minimum timing, STROBE_HIGH=1, STROBE_LOW=2.**
  - Required response: edges are spaced 3 cycles apart.
  - The receiver latches all bytes, with no missed edge after any even nibble.
- **start while busy.** Pulse start at cycle 20 with different params.
  - Required response: no effect.
  - The frame completes with the original bytes, and the next IDLE start sends the new set.
- **Async reset mid-frame.** Assert rst_n=0 at strobe 9.
  - Required response: all outputs go to 0 immediately.
  - The receiver returns to idle, its committed parameters are unchanged, and ready=0.
- **Back-to-back frames.** Hold start high continuously.
  - Required response: a new frame is accepted on the IDLE cycle after DONE.
  - load_mode shows a low gap of at least 1 cycle between frames, and both frames commit.
- **All-0xFF params.**
  - Required response: data nibbles all 0xF, and the receiver commits 0xFF to every register.
  - This shows footer-valued data does not terminate the frame early.
